// File: rtl/counter_pkg.sv
// counter_pkg: shared types and register map for the counter_compare alarm stage.
package counter_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, FIRED} cmp_state_t;
  localparam logic [1:0] ADDR_DEADLINE = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
endpackage

// File: rtl/wrap_compare.sv
// wrap_compare: wrap-safe a >= b, valid while the distance is under half the range.
module wrap_compare #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_ge
);
  logic [W-1:0] w_diff;
  assign w_diff = i_a - i_b;
  assign o_ge = !w_diff[W-1];
endmodule

// File: rtl/counter_compare.sv
// counter_compare: deadline/period alarm on an upstream free-running count.
// Define COUNTER_COMPARE_OVERRUN_EN to add the overrun_cnt port and counter.
module counter_compare
  import counter_pkg::*;
#(
  parameter int COUNTER_BIT_WIDTH = 32,
  parameter int OVERRUN_BIT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COUNTER_BIT_WIDTH-1:0] count_in,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_addr,
  input  logic [COUNTER_BIT_WIDTH-1:0] wr_data,
  input  logic                         irq_ack,
  output logic                         irq,
  output logic                         armed,
  output logic [COUNTER_BIT_WIDTH-1:0] deadline_out
`ifdef COUNTER_COMPARE_OVERRUN_EN
  ,
  output logic [OVERRUN_BIT_WIDTH-1:0] overrun_cnt
`endif
);
  cmp_state_t r_state;
  logic [COUNTER_BIT_WIDTH-1:0] r_deadline, r_period;
  logic r_en, r_periodic, r_irq;
  logic w_hit, w_ctrl_wr, w_dl_wr, w_pd, w_fire, w_ack;
  wrap_compare #(.W(COUNTER_BIT_WIDTH)) u_cmp (
    .i_a (count_in),
    .i_b (r_deadline),
    .o_ge(w_hit)
  );
  assign w_ctrl_wr = wr_en && wr_addr == ADDR_CTRL;
  assign w_dl_wr = wr_en && wr_addr == ADDR_DEADLINE;
  assign w_pd = r_periodic && |r_period;
  // A CTRL write suppresses hit and ack processing on its edge.
  assign w_fire = !w_ctrl_wr && r_en && w_hit && (r_state == ARMED || (r_state == FIRED && w_pd));
  assign w_ack = !w_ctrl_wr && irq_ack && r_state == FIRED;
  assign irq = r_irq;
  assign armed = r_state != IDLE;
  assign deadline_out = r_deadline;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_deadline <= '0;
      r_period <= '0;
      r_en <= 1'b0;
      r_periodic <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_dl_wr) r_deadline <= wr_data;
      else if (w_fire && w_pd) r_deadline <= r_deadline + r_period;
      if (wr_en && wr_addr == ADDR_PERIOD) r_period <= wr_data;
      if (w_ctrl_wr) begin
        r_en <= wr_data[CTRL_EN_BIT];
        r_periodic <= wr_data[CTRL_PERIODIC_BIT];
        r_state <= !wr_data[CTRL_EN_BIT] ? IDLE : r_state == IDLE ? ARMED : r_state;
        r_irq <= wr_data[CTRL_EN_BIT] && r_irq;
      end else if (w_fire) begin
        r_state <= FIRED;
        r_irq <= 1'b1;
      end else if (w_ack) begin
        r_state <= w_pd ? ARMED : IDLE;
        r_en <= w_pd;
        r_irq <= 1'b0;
      end
    end
  end
`ifdef COUNTER_COMPARE_OVERRUN_EN
  logic [OVERRUN_BIT_WIDTH-1:0] r_ovr;
  assign overrun_cnt = r_ovr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ovr <= '0;
    else if (w_ctrl_wr || (w_ack && !w_fire)) r_ovr <= '0;
    else if (w_fire && r_state == FIRED && !irq_ack && !(&r_ovr)) r_ovr <= r_ovr + 1'b1;
  end
`endif
endmodule

// File: tb/tb_counter_compare.sv
// tb_counter_compare: directed checks of one-shot, periodic, wrap, overrun, collision and reset behaviour.
module tb_counter_compare;
  import counter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] count_in = '0;
  logic wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic irq_ack = 1'b0;
  logic irq, armed;
  logic [31:0] deadline_out;
  logic seen_irq;
  int checks = 0;
  int failures = 0;
`ifdef COUNTER_COMPARE_OVERRUN_EN
  logic [7:0] overrun_cnt;
`endif
  counter_compare dut (
    .clk(clk),
    .rst(rst),
    .count_in(count_in),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .irq_ack(irq_ack),
    .irq(irq),
    .armed(armed),
    .deadline_out(deadline_out)
`ifdef COUNTER_COMPARE_OVERRUN_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task tick;
    @(posedge clk);
    #1;
    count_in = count_in + 1;
  endtask
  task wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task ack;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask
  task run_to(input logic [31:0] t);
    seen_irq = 1'b0;
    for (int n = 0; n < 2000 && count_in != t; n++) begin
      tick();
      seen_irq = seen_irq | irq;
    end
    chk("reach", count_in, t);
  endtask
  task do_reset(input logic [31:0] start);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    count_in = start;
    rst = 1'b1;
  endtask
  initial begin
    do_reset(32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_deadline", deadline_out, 32'd0);
    // one-shot
    wr(ADDR_DEADLINE, 32'd100);
    chk("dl_no_arm", {31'd0, armed}, 32'd0);
    chk("dl_out", deadline_out, 32'd100);
    wr(ADDR_CTRL, 32'd1);
    chk("os_armed", {31'd0, armed}, 32'd1);
    run_to(32'd100);
    chk("os_early", {31'd0, seen_irq}, 32'd0);
    tick();
    chk("os_irq", {31'd0, irq}, 32'd1);
    ack();
    chk("os_ack_irq", {31'd0, irq}, 32'd0);
    chk("os_ack_armed", {31'd0, armed}, 32'd0);
    repeat (5) tick();
    chk("os_quiet", {31'd0, irq}, 32'd0);
    // periodic
    do_reset(32'd0);
    wr(ADDR_DEADLINE, 32'd50);
    wr(ADDR_PERIOD, 32'd20);
    wr(ADDR_CTRL, 32'd3);
    for (int k = 0; k < 3; k++) begin
      run_to(32'd50 + 32'd20 * k);
      chk("per_early", {31'd0, seen_irq}, 32'd0);
      tick();
      chk("per_irq", {31'd0, irq}, 32'd1);
      chk("per_dl", deadline_out, 32'd70 + 32'd20 * k);
      repeat (2) tick();
      ack();
      chk("per_ack_irq", {31'd0, irq}, 32'd0);
      chk("per_ack_armed", {31'd0, armed}, 32'd1);
    end
    chk("per_dl_final", deadline_out, 32'd110);
    // overrun: hits at 20, then 30/40/50 while unacknowledged
    do_reset(32'd0);
    wr(ADDR_DEADLINE, 32'd20);
    wr(ADDR_PERIOD, 32'd10);
    wr(ADDR_CTRL, 32'd3);
    run_to(32'd20);
    tick();
    chk("ovr_first", {31'd0, irq}, 32'd1);
    repeat (35) tick();
    chk("ovr_irq_held", {31'd0, irq}, 32'd1);
    chk("ovr_dl", deadline_out, 32'd60);
`ifdef COUNTER_COMPARE_OVERRUN_EN
    chk("ovr_cnt", {24'd0, overrun_cnt}, 32'd3);
`endif
    ack();
    chk("ovr_ack_irq", {31'd0, irq}, 32'd0);
`ifdef COUNTER_COMPARE_OVERRUN_EN
    chk("ovr_ack_cnt", {24'd0, overrun_cnt}, 32'd0);
`endif
    // ack coincident with a periodic hit: hit wins
    run_to(32'd60);
    tick();
    chk("sim_fire", {31'd0, irq}, 32'd1);
    run_to(32'd70);
    ack();
    chk("sim_irq", {31'd0, irq}, 32'd1);
    chk("sim_dl", deadline_out, 32'd80);
`ifdef COUNTER_COMPARE_OVERRUN_EN
    chk("sim_ovr", {24'd0, overrun_cnt}, 32'd0);
`endif
    // CTRL disable on a hit edge
    run_to(32'd80);
    wr(ADDR_CTRL, 32'd0);
    chk("dis_irq", {31'd0, irq}, 32'd0);
    chk("dis_armed", {31'd0, armed}, 32'd0);
    // wrap across zero
    do_reset(32'hFFFF_FFF0);
    wr(ADDR_DEADLINE, 32'd8);
    wr(ADDR_CTRL, 32'd1);
    run_to(32'd8);
    chk("wrap_early", {31'd0, seen_irq}, 32'd0);
    tick();
    chk("wrap_irq", {31'd0, irq}, 32'd1);
    // asynchronous reset while FIRED
    #2;
    rst = 1'b0;
    #1;
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_armed", {31'd0, armed}, 32'd0);
    chk("async_dl", deadline_out, 32'd0);
    #2;
    rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_armed", {31'd0, armed}, 32'd0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    wr(ADDR_CTRL, 32'd1);
    chk("rearm", {31'd0, armed}, 32'd1);
    tick();
    chk("rearm_irq", {31'd0, irq}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_compare.md
# counter_compare

Compare/alarm stage that sits directly downstream of the free-running `counter` and consumes its `data_out` value. Software programs a deadline, an optional period and a mode through a simple write port. The block raises a level interrupt when the count reaches the deadline, with wrap-safe comparison. In periodic mode it re-arms itself by advancing the deadline by the period.

## Interface
- `COUNTER_BIT_WIDTH`, default 32: width of `count_in`, deadline, period and `deadline_out`.
- `OVERRUN_BIT_WIDTH`, default 8: width of `overrun_cnt`; it is only present when `COUNTER_COMPARE_OVERRUN_EN` is defined.
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `count_in`  in  COUNTER_BIT_WIDTH: counter value from the upstream `counter.data_out`.
- `wr_en`  in  1: register write strobe, one write per cycle.
- `wr_addr`  in  2: register select.
  - 0: DEADLINE.
  - 1: PERIOD.
  - 2: CTRL (bit0 enable, bit1 periodic).
  - 3: reserved; writes are ignored.
- `wr_data`  in  COUNTER_BIT_WIDTH: write data.
- `irq_ack`  in  1: single-cycle interrupt acknowledge.
- `irq`  out  1: pending interrupt, level-high.
- `armed`  out  1: high in ARMED or FIRED.
- `deadline_out`  out  COUNTER_BIT_WIDTH: current deadline register.
- `overrun_cnt`  out  OVERRUN_BIT_WIDTH: missed periodic hits (macro only).

## Operation
- **Registers**: deadline, period, enable, periodic. All are 0 after reset.
- **Hit**: `hit = ((count_in - deadline) mod 2^W)[W-1] == 0`.
  - This is a wrap-safe "count ≥ deadline" test, valid while the distance is under 2^(W-1).
- **States**: IDLE, ARMED, FIRED.
- **IDLE**:
  - A CTRL write with enable=1 moves to ARMED.
  - A DEADLINE write does not arm the block.
- **ARMED**:
  - On `hit`, move to FIRED.
  - If periodic=1 and period≠0, the same edge also sets `deadline <= deadline + period` (mod 2^W).
- **FIRED, one-shot mode**:
  - `irq_ack` moves to IDLE and clears enable.
  - No further compares are made.
- **FIRED, periodic mode**:
  - Compares continue.
  - A further `hit` reloads the deadline again and counts an overrun.
  - `irq_ack` moves to ARMED.
- **Period of zero**: periodic=1 with period=0 behaves as one-shot.
- **Simultaneous ack and hit in periodic FIRED**: the hit wins.
  - The state stays FIRED and `irq` stays 1.
  - The deadline reloads.
  - No overrun is counted.
- **CTRL write with enable=0**: moves to IDLE from any state and clears `irq` on the same edge. This has priority over hit and ack.
- **DEADLINE write while ARMED or FIRED**:
  - The deadline is replaced.
  - The state is unchanged.
  - The written value takes precedence over a reload on the same edge.
  - A hit on that edge is still evaluated against the old deadline.
- **`irq_ack` outside FIRED**: ignored.

## Timing
- `count_in` is sampled combinationally and all state is registered.
- `irq` rises on the first rising edge at which `count_in` satisfies `hit` while ARMED.
  - It is visible in the cycle after the counter value equals the deadline.
- `irq` falls at the edge where `irq_ack` is sampled high (subject to the simultaneous ack-and-hit rule).
- Register writes take effect at the edge they are sampled; `deadline_out` reflects the write the next cycle.
- **Reset**: asserting `rst` low immediately forces all outputs low.
  - `irq=0`, `armed=0`, `deadline_out=0`, `overrun_cnt=0`, state IDLE.
  - This applies mid-operation as well, independent of `clk`.

## Configuration
- `COUNTER_COMPARE_OVERRUN_EN`
  - **Defined**: `overrun_cnt` port and logic are present.
    - Increments on each hit in periodic FIRED without a same-cycle ack.
    - Saturates at all-ones.
    - Clears on `irq_ack` and on any CTRL write.
  - **Undefined**: port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `counter_pkg`:
  - state enum `cmp_state_t` {IDLE, ARMED, FIRED};
  - register address constants `ADDR_DEADLINE`, `ADDR_PERIOD`, `ADDR_CTRL`;
  - CTRL bit indices.
- One sub-module, `wrap_compare`: a combinational wrap-safe ≥ comparator, parameterised by width.
- FSM and registers live in the top module.

## Test plan
- **One-shot**: counter from reset, DEADLINE=100, CTRL=1 → `irq` rises at the edge where `count_in` is 100. Ack → IDLE, `armed=0`, no further irq.
- **Periodic**: DEADLINE=50, PERIOD=20, CTRL=3, ack each irq within 5 cycles → irqs on counts 50, 70, 90 and `deadline_out` reads 110 after the third hit.
- **Wrap**: `count_in` driven from 0xFFFF_FFF0, DEADLINE=0x0000_0008 → no irq before the wrap; irq at count 8.
- **Overrun** (macro defined): PERIOD=10, no ack for 35 cycles after the first hit → `overrun_cnt=3`, `irq` held 1. Ack → `overrun_cnt=0`.
- **Simultaneous events**:
  - Ack on the same cycle as a periodic hit → `irq` stays 1 and `overrun_cnt` is unchanged.
  - CTRL=0 on a hit cycle → IDLE and `irq=0`.
- **Reset mid-FIRED**: pull `rst` low between clock edges → all outputs 0 immediately. After release the block stays IDLE until re-enabled.
